// File: rtl/dense_layer.sv
// Fully-connected output stage: per-class ternary/2-bit weighted accumulation of a flattened
// feature vector followed by a sequential argmax. Optional macro DENSE_SATURATE_EN clamps the adds.
module dense_layer #(
    parameter int FLATTENED_LENGTH = 50,
    parameter int NUM_CLASSES      = 2,
    parameter int DATA_WIDTH       = 8,
    parameter int ACC_WIDTH        = 16
) (
    input  logic                                  clk,
    input  logic                                  rst_cnn,
    input  logic [2*FLATTENED_LENGTH-1:0]         weights_input,
    input  logic [$clog2(NUM_CLASSES)-1:0]        weight_writeAddr,
    input  logic                                  weights_WrEn,
    input  logic [DATA_WIDTH-1:0]                 in_data,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    output logic [NUM_CLASSES*ACC_WIDTH-1:0]      scores,
    output logic [$clog2(NUM_CLASSES)-1:0]        class_out,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic                                  busy
);

    localparam int CLS_W = $clog2(NUM_CLASSES);
    localparam int CNT_W = (FLATTENED_LENGTH > 1) ? $clog2(FLATTENED_LENGTH) : 1;
    localparam int SUM_W = ACC_WIDTH + DATA_WIDTH + 3;

    localparam logic [CNT_W-1:0] LAST_ELEM = CNT_W'(FLATTENED_LENGTH - 1);
    localparam logic [CLS_W-1:0] LAST_CLS  = CLS_W'(NUM_CLASSES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_ARGMAX = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t                          r_state;
    state_t                          w_state_next;
    logic [2*FLATTENED_LENGTH-1:0]   r_weights [NUM_CLASSES];
    logic signed [ACC_WIDTH-1:0]     r_acc     [NUM_CLASSES];
    logic signed [ACC_WIDTH-1:0]     w_acc_next[NUM_CLASSES];
    logic [CNT_W-1:0]                r_elem_cnt;
    logic [CLS_W-1:0]                r_cidx;
    logic signed [ACC_WIDTH-1:0]     r_best;
    logic [CLS_W-1:0]                r_idx;
    logic                            r_out_valid;
    logic                            w_in_ready;
    logic                            w_busy;
    logic                            w_accept;
    logic                            w_take;

`ifdef DENSE_SATURATE_EN
    localparam logic signed [SUM_W-1:0] SAT_MAX =
        {{(SUM_W-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN =
        {{(SUM_W-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};

    // Clamp a wide exact sum into the signed accumulator range.
    function automatic logic signed [ACC_WIDTH-1:0] f_sat(input logic signed [SUM_W-1:0] v);
        logic signed [ACC_WIDTH-1:0] res;
        if (v > SAT_MAX) begin
            res = SAT_MAX[ACC_WIDTH-1:0];
        end else if (v < SAT_MIN) begin
            res = SAT_MIN[ACC_WIDTH-1:0];
        end else begin
            res = v[ACC_WIDTH-1:0];
        end
        return res;
    endfunction
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_cnn) begin
        if (!rst_cnn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and state-decoded handshake/status outputs.
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_busy       = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b0;
                if (in_valid && (r_elem_cnt == LAST_ELEM)) begin
                    w_state_next = S_ARGMAX;
                end else if (in_valid) begin
                    w_state_next = S_ACCUM;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_ACCUM: begin
                w_in_ready = 1'b1;
                if (in_valid && (r_elem_cnt == LAST_ELEM)) begin
                    w_state_next = S_ARGMAX;
                end else begin
                    w_state_next = S_ACCUM;
                end
            end
            S_ARGMAX: begin
                if (r_cidx == LAST_CLS) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_ARGMAX;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_DONE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_busy       = 1'b0;
            end
        endcase
    end

    assign w_accept = in_valid & w_in_ready;

    // Per-class multiply-accumulate; the first element of an inference starts from zero.
    always_comb begin
        logic signed [SUM_W-1:0] v_x;
        logic signed [SUM_W-1:0] v_w;
        logic signed [SUM_W-1:0] v_base;
        logic signed [SUM_W-1:0] v_sum;
        logic [1:0]              v_wbits;
        v_x = {{(SUM_W-DATA_WIDTH){1'b0}}, in_data};
        for (int c = 0; c < NUM_CLASSES; c++) begin
            v_wbits = r_weights[c][{r_elem_cnt, 1'b0} +: 2];
            v_w     = {{(SUM_W-2){v_wbits[1]}}, v_wbits};
            if (r_state == S_IDLE) begin
                v_base = '0;
            end else begin
                v_base = {{(SUM_W-ACC_WIDTH){r_acc[c][ACC_WIDTH-1]}}, r_acc[c]};
            end
            v_sum = v_base + (v_x * v_w);
`ifdef DENSE_SATURATE_EN
            w_acc_next[c] = f_sat(v_sum);
`else
            w_acc_next[c] = v_sum[ACC_WIDTH-1:0];
`endif
        end
    end

    // Weight memory: rows are writable only while idle.
    always_ff @(posedge clk or negedge rst_cnn) begin
        if (!rst_cnn) begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                r_weights[c] <= '0;
            end
        end else if ((r_state == S_IDLE) && !weights_WrEn
                     && (int'(weight_writeAddr) < NUM_CLASSES)) begin
            r_weights[weight_writeAddr] <= weights_input;
        end
    end

    // Accumulators and element counter.
    always_ff @(posedge clk or negedge rst_cnn) begin
        if (!rst_cnn) begin
            for (int c = 0; c < NUM_CLASSES; c++) begin
                r_acc[c] <= '0;
            end
            r_elem_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_ACCUM: begin
                    if (w_accept) begin
                        for (int c = 0; c < NUM_CLASSES; c++) begin
                            r_acc[c] <= w_acc_next[c];
                        end
                        r_elem_cnt <= (r_elem_cnt == LAST_ELEM) ? '0 : r_elem_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        for (int c = 0; c < NUM_CLASSES; c++) begin
                            r_acc[c] <= '0;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Strict greater-than keeps the lowest index on ties.
    assign w_take = (r_cidx == '0) || (r_acc[r_cidx] > r_best);

    // Sequential argmax scan and result-valid flag.
    always_ff @(posedge clk or negedge rst_cnn) begin
        if (!rst_cnn) begin
            r_cidx      <= '0;
            r_best      <= '0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_ARGMAX: begin
                    if (w_take) begin
                        r_best <= r_acc[r_cidx];
                        r_idx  <= r_cidx;
                    end
                    if (r_cidx == LAST_CLS) begin
                        r_cidx      <= '0;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_cidx <= r_cidx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Flatten the accumulators onto the score bus.
    always_comb begin
        scores = '0;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            scores[c*ACC_WIDTH +: ACC_WIDTH] = r_acc[c];
        end
    end

    assign in_ready  = w_in_ready;
    assign busy      = w_busy;
    assign out_valid = r_out_valid;
    assign class_out = r_idx;

endmodule
